// File: rtl/l2_page_server.sv
// l2_page_server: answers icache page-fill requests by reading one 16-bit
// word at a time from backing memory and streaming the words back in order.
// Ports: clk, rst (async, active low)
//   l2_start/l2_page in; l2_busy/l2_launch/l2_ready/l2_data out
//   mem_req/mem_addr out; mem_ack/mem_rdata in
module l2_page_server #(
  parameter int WIDTH      = 32,
  parameter int PAGE_BYTES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l2_start,
  input  logic [WIDTH-1:0] l2_page,
  output logic             l2_busy,
  output logic             l2_launch,
  output logic             l2_ready,
  output logic [15:0]      l2_data,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [15:0]      mem_rdata
);

  localparam int NW = PAGE_BYTES / 2;
  localparam int PB = $clog2(PAGE_BYTES);
  localparam int AW = $clog2(NW);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    READ,
    DELIVER,
    LAST
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] base;
  logic [AW-1:0]    wc;
  logic             last_wc;
  logic             take;

  assign last_wc  = (wc == AW'(NW - 1));
  assign take     = mem_req && mem_ack;
  // page is aligned, so adding the word offset never carries into base bits
  assign mem_addr = base + WIDTH'({wc, 1'b0});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // LAUNCH already drives the first read, so an ack there
  // skips straight to delivery for the 2-cycle start latency
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (l2_start) nxt = LAUNCH;
      end
      LAUNCH, READ: begin
        if (mem_ack) nxt = last_wc ? LAST : DELIVER;
        else         nxt = READ;
      end
      DELIVER: nxt = READ;
      LAST:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    l2_busy   = (state != IDLE);
    l2_launch = (state == LAUNCH);
    l2_ready  = (state == DELIVER) || (state == LAST);
    mem_req   = (state == LAUNCH) || (state == READ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base    <= '0;
      wc      <= '0;
      l2_data <= '0;
    end else begin
      if (state == IDLE && l2_start) begin
        base <= {l2_page[WIDTH-1:PB], {PB{1'b0}}};
        wc   <= '0;
      end
      if (take) l2_data <= mem_rdata;
      if (state == DELIVER) wc <= wc + 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_page_server.sv
// tb_l2_page_server: random-delay memory responder plus a page-level
// reference model of the word order, addresses and strobe timing.
module tb_l2_page_server;

  localparam int WIDTH      = 32;
  localparam int PAGE_BYTES = 32;
  localparam int NW         = PAGE_BYTES / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pg = '0;
  logic             busy;
  logic             launch;
  logic             ready;
  logic [15:0]      data;
  logic             req;
  logic [WIDTH-1:0] addr;
  logic             ack = 1'b0;
  logic [15:0]      rdata = '0;

  l2_page_server #(.WIDTH(WIDTH), .PAGE_BYTES(PAGE_BYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .l2_start  (start),
    .l2_page   (pg),
    .l2_busy   (busy),
    .l2_launch (launch),
    .l2_ready  (ready),
    .l2_data   (data),
    .mem_req   (req),
    .mem_addr  (addr),
    .mem_ack   (ack),
    .mem_rdata (rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int               dly [NW];
  int               req_idx = 0;
  logic [15:0]      got_q [$];
  int               rcyc_q [$];
  logic [WIDTH-1:0] addr_q [$];
  int               launches = 0;
  int               lcyc = -1;

  // memory: ack after dly[k] cycles for the k-th read of a burst,
  // random junk acks whenever no read is outstanding
  bit               pending = 1'b0;
  int               wleft = 0;
  logic [WIDTH-1:0] raddr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      pending = 1'b0;
      ack     = 1'b0;
    end else if (req) begin
      if (!pending) begin
        pending = 1'b1;
        wleft   = (req_idx < NW) ? dly[req_idx] : 0;
        raddr   = addr;
      end
      chk("addr_hold", addr, raddr);
      if (wleft == 0) begin
        ack     = 1'b1;
        rdata   = raddr[16:1];
        pending = 1'b0;
        addr_q.push_back(raddr);
        req_idx++;
      end else begin
        ack   = 1'b0;
        rdata = 16'($urandom);
        wleft--;
      end
    end else begin
      pending = 1'b0;
      ack     = ($urandom_range(0, 3) == 0);
      rdata   = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (ready) begin
        got_q.push_back(data);
        rcyc_q.push_back(cyc);
      end
      if (launch) begin
        launches++;
        lcyc = cyc;
      end
    end
  end

  task automatic zero_dly();
    for (int k = 0; k < NW; k++) dly[k] = 0;
  endtask

  task automatic rand_dly();
    for (int k = 0; k < NW; k++)
      dly[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
  endtask

  // caller is just past a negedge; returns at the first negedge with busy=0
  task automatic run_fill(input logic [WIDTH-1:0] page, input bit poke);
    int               t0;
    int               n;
    int               acc;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] wa;
    got_q.delete();
    rcyc_q.delete();
    addr_q.delete();
    launches = 0;
    lcyc     = -1;
    req_idx  = 0;
    base  = page & ~WIDTH'(PAGE_BYTES - 1);
    start = 1'b1;
    pg    = page;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      if (poke && n == 9) begin
        start = 1'b1;
        pg    = 32'h0000_8000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("fill_done", 64'(n < 2000), 64'd1);
    chk("launch_cnt", 64'(launches), 64'd1);
    chk("launch_cyc", 64'(lcyc), 64'(t0 + 1));
    chk("ready_cnt", 64'(got_q.size()), 64'(NW));
    chk("addr_cnt", 64'(addr_q.size()), 64'(NW));
    acc = 0;
    for (int k = 0; k < NW; k++) begin
      acc += dly[k];
      wa = base + WIDTH'(2 * k);
      if (k < got_q.size()) begin
        chk("data", 64'(got_q[k]), 64'(wa[16:1]));
        chk("ready_cyc", 64'(rcyc_q[k]), 64'(t0 + 2 + 2 * k + acc));
      end
      if (k < addr_q.size()) chk("mem_addr", 64'(addr_q[k]), 64'(wa));
    end
    chk("busy_fall", 64'(cyc), 64'(t0 + 2 * NW + acc + 1));
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_launch"}, 64'(launch), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_req"}, 64'(req), 64'd0);
  endtask

  task automatic mid_reset();
    int n;
    int seen;
    zero_dly();
    req_idx = 0;
    start   = 1'b1;
    pg      = 32'h0003_5A7C;
    @(negedge clk);
    start = 1'b0;
    n    = 0;
    seen = 0;
    while (seen < 8 && n < 200) begin
      if (ready) seen++;
      if (seen < 8) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mid_word7", 64'(seen), 64'd8);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    idle_outs("arst");
    chk("arst_data", 64'(data), 64'd0);
    chk("arst_addr", 64'(addr), 64'd0);
    repeat (3) begin
      @(negedge clk);
      idle_outs("inrst");
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    idle_outs("postrst");
  endtask

  initial begin
    zero_dly();
    repeat (3) begin
      @(negedge clk);
      idle_outs("rst");
      chk("rst_data", 64'(data), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      idle_outs("idle");
      chk("idle_data", 64'(data), 64'd0);
    end

    run_fill(32'h0000_1234, 1'b0);
    repeat (2) @(negedge clk);

    zero_dly();
    dly[3] = 5;
    run_fill(32'h0000_1234, 1'b0);
    repeat (2) @(negedge clk);

    zero_dly();
    run_fill(32'h4000_0010, 1'b1);
    @(negedge clk);

    run_fill(32'h2000_0042, 1'b0);
    run_fill(32'h0000_ABCD, 1'b0);
    @(negedge clk);

    mid_reset();
    run_fill(32'h0003_5A7C, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rand_dly();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_fill(32'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
